// File: rtl/i2c_register_target.sv
// I2C target with a 256x8 register bank, pointer auto-increment,
// combined-format reads and a local write-notify / read-back port.
module i2c_register_target #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h3D,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       i2c_serial_clock,
    inout  wire        i2c_serial_data,
    output logic       write_strobe,
    output logic [7:0] write_address,
    output logic [7:0] write_data,
    input  logic [7:0] local_address,
    output logic [7:0] local_data,
    output logic       busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] ACK_A  = 3'd2;
    localparam logic [2:0] REG    = 3'd3;
    localparam logic [2:0] WDATA  = 3'd4;
    localparam logic [2:0] RDATA  = 3'd5;
    localparam logic [2:0] IGNORE = 3'd6;

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_seen;
    logic                   stop_seen;

    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic [7:0] tx_shift;
    logic [7:0] pointer;
    logic       rw;
    logic       sda_low;
    logic [7:0] regs [256];

    // Reset gates the driver directly so the bus is freed without waiting a clock.
    assign i2c_serial_data = (sda_low && !reset) ? 1'b0 : 1'bz;

    assign scl_s      = scl_pipe[SYNC_STAGES-1];
    assign sda_s      = sda_pipe[SYNC_STAGES-1];
    assign scl_rise   = scl_s && !scl_q;
    assign scl_fall   = !scl_s && scl_q;
    assign start_seen = scl_s && scl_q && sda_q && !sda_s;
    assign stop_seen  = scl_s && scl_q && !sda_q && sda_s;
    assign rx_byte    = {rx_shift, sda_s};
    assign busy       = (state != IDLE);

    always_ff @(posedge clock_25) begin
        if (reset) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], i2c_serial_clock};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], i2c_serial_data};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= 4'd0;
            rx_shift      <= 7'd0;
            tx_shift      <= 8'd0;
            pointer       <= 8'd0;
            rw            <= 1'b0;
            sda_low       <= 1'b0;
            write_strobe  <= 1'b0;
            write_address <= 8'd0;
            write_data    <= 8'd0;
            local_data    <= 8'd0;
            for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
        end else begin
            write_strobe <= 1'b0;
            local_data   <= regs[local_address];
            if (stop_seen) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
            end else if (start_seen) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
            end else if (scl_rise) begin
                if (state != IDLE && state != IGNORE && bit_cnt != 4'd9)
                    bit_cnt <= bit_cnt + 4'd1;
                rx_shift <= rx_byte[6:0];
                case (state)
                    ADDR: if (bit_cnt == 4'd7) begin
                        if (rx_byte[7:1] == DEVICE_ADDRESS) begin
                            state <= ACK_A;
                            rw    <= rx_byte[0];
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    REG: if (bit_cnt == 4'd7) pointer <= rx_byte;
                    WDATA: if (bit_cnt == 4'd7) begin
                        regs[pointer] <= rx_byte;
                        write_strobe  <= 1'b1;
                        write_address <= pointer;
                        write_data    <= rx_byte;
                        pointer       <= pointer + 8'd1;
                    end
                    // Ninth rise of a read byte carries the master's ACK/NACK.
                    RDATA: if (bit_cnt == 4'd8) begin
                        if (!sda_s) pointer <= pointer + 8'd1;
                        else        state   <= IGNORE;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ACK_A: begin
                        if (bit_cnt == 4'd8) sda_low <= 1'b1;
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                state    <= RDATA;
                                tx_shift <= regs[pointer];
                                sda_low  <= ~regs[pointer][7];
                            end else begin
                                state   <= REG;
                                sda_low <= 1'b0;
                            end
                        end
                    end
                    REG, WDATA: begin
                        if (bit_cnt == 4'd8) sda_low <= 1'b1;
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= 4'd0;
                            sda_low <= 1'b0;
                            state   <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (bit_cnt >= 4'd1 && bit_cnt <= 4'd7) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            sda_low  <= ~tx_shift[6];
                        end
                        if (bit_cnt == 4'd8) sda_low <= 1'b0;
                        if (bit_cnt == 4'd9) begin
                            bit_cnt  <= 4'd0;
                            tx_shift <= regs[pointer];
                            sda_low  <= ~regs[pointer][7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_register_target.sv
// Directed bench for i2c_register_target: bit-banged I2C master,
// strobe monitor and local-port readback against hand-computed values.
module tb_i2c_register_target;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b0;
    wire        sda;
    logic       write_strobe;
    logic [7:0] write_address;
    logic [7:0] write_data;
    logic [7:0] local_address = 8'h00;
    logic [7:0] local_data;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int n_strobe = 0;
    logic [7:0] last_wa = 8'h00;
    logic [7:0] last_wd = 8'h00;

    assign sda = sda_drv ? 1'b0 : 1'bz;
    pullup (sda);

    always #20 clk = ~clk;

    i2c_register_target dut (
        .clock_25        (clk),
        .reset           (reset),
        .i2c_serial_clock(scl),
        .i2c_serial_data (sda),
        .write_strobe    (write_strobe),
        .write_address   (write_address),
        .write_data      (write_data),
        .local_address   (local_address),
        .local_data      (local_data),
        .busy            (busy)
    );

    always @(negedge clk) begin
        if (write_strobe === 1'b1) begin
            n_strobe = n_strobe + 1;
            last_wa  = write_address;
            last_wd  = write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        wq(); sda_drv = 1'b0;
        wq(); scl = 1'b1;
        wq(); sda_drv = 1'b1;
        wq(); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wq(); sda_drv = 1'b1;
        wq(); scl = 1'b1;
        wq(); sda_drv = 1'b0;
        wq();
    endtask

    task automatic send_bit(input logic b);
        wq(); sda_drv = ~b;
        wq(); scl = 1'b1;
        wq(); wq(); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wq(); sda_drv = 1'b0;
        wq(); scl = 1'b1;
        wq(); ack = sda;
        wq(); scl = 1'b0;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            wq(); sda_drv = 1'b0;
            wq(); scl = 1'b1;
            wq(); d[i] = sda;
            wq(); scl = 1'b0;
        end
        wq(); sda_drv = mack;
        wq(); scl = 1'b1;
        wq(); wq(); scl = 1'b0;
        wq(); sda_drv = 1'b0;
    endtask

    task automatic read_local(input logic [7:0] a, output logic [7:0] d);
        local_address = a;
        repeat (2) @(posedge clk);
        @(negedge clk);
        d = local_data;
    endtask

    task automatic write3(input logic [7:0] r, input logic [7:0] v,
                          input string tag);
        logic a0, a1, a2;
        i2c_start();
        send_byte(8'h7A, a0);
        send_byte(r, a1);
        send_byte(v, a2);
        i2c_stop();
        check({tag, "_acks"}, {a0, a1, a2}, 3'b000);
    endtask

    initial begin
        logic       a0, a1, a2, a3, a4;
        logic [7:0] d;
        int         s0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_strobe", write_strobe, 1'b0);
        check("rst_sda", sda, 1'b1);
        check("rst_local", local_data, 8'h00);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // T1 single write
        i2c_start();
        @(negedge clk);
        check("t1_busy", busy, 1'b1);
        send_byte(8'h7A, a0);
        send_byte(8'h16, a1);
        send_byte(8'h61, a2);
        i2c_stop();
        check("t1_acks", {a0, a1, a2}, 3'b000);
        check("t1_nstrobe", n_strobe, 1);
        check("t1_waddr", last_wa, 8'h16);
        check("t1_wdata", last_wd, 8'h61);
        check("t1_busy_end", busy, 1'b0);
        local_address = 8'h16;
        @(posedge clk);
        @(posedge clk);
        #1 check("t1_local", local_data, 8'h61);

        // T2 wrap of pointer across 0xFF
        write3(8'h01, 8'h5A, "t2pre");
        s0 = n_strobe;
        i2c_start();
        send_byte(8'h7A, a0);
        send_byte(8'hFE, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        send_byte(8'h33, a4);
        i2c_stop();
        check("t2_acks", {a0, a1, a2, a3, a4}, 5'b0);
        check("t2_nstrobe", n_strobe - s0, 3);
        read_local(8'hFE, d); check("t2_fe", d, 8'h11);
        read_local(8'hFF, d); check("t2_ff", d, 8'h22);
        read_local(8'h00, d); check("t2_00", d, 8'h33);
        i2c_start();
        send_byte(8'h7B, a0);
        read_byte(1'b0, d);
        i2c_stop();
        check("t2_rd_ack", a0, 1'b0);
        check("t2_ptr01", d, 8'h5A);

        // T3 combined read with repeated START
        write3(8'h40, 8'h55, "t3pre");
        i2c_start();
        send_byte(8'h7A, a0);
        send_byte(8'h56, a1);
        i2c_stop();
        write3(8'h41, 8'h66, "t3pre2");
        s0 = n_strobe;
        i2c_start();
        send_byte(8'h7A, a0);
        send_byte(8'h40, a1);
        i2c_start();
        send_byte(8'h7B, a2);
        check("t3_acks", {a0, a1, a2}, 3'b000);
        read_byte(1'b1, d);
        check("t3_byte0", d, 8'h55);
        read_byte(1'b0, d);
        check("t3_byte1", d, 8'h66);
        wq();
        check("t3_sda_rel", sda, 1'b1);
        i2c_stop();
        check("t3_nostrobe", n_strobe - s0, 0);

        // T4 foreign address is ignored until STOP
        s0 = n_strobe;
        i2c_start();
        send_byte(8'h7C, a0);
        send_byte(8'h16, a1);
        send_byte(8'h99, a2);
        i2c_stop();
        check("t4_nack", {a0, a1, a2}, 3'b111);
        check("t4_nostrobe", n_strobe - s0, 0);
        write3(8'h20, 8'h77, "t4");
        read_local(8'h20, d); check("t4_local", d, 8'h77);

        // T5 reset while ACK is driven
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(logic'(8'h7A >> i));
        wq(); sda_drv = 1'b0;
        wq();
        check("t5_ack_low", sda, 1'b0);
        reset = 1'b1;
        #1 check("t5_sda_rel", sda, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        reset = 1'b0;
        read_local(8'h16, d); check("t5_reg16", d, 8'h00);
        write3(8'h16, 8'h44, "t5");
        read_local(8'h16, d); check("t5_reg16_new", d, 8'h44);

        // T6 payload aborted by STOP after 4 bits
        write3(8'h30, 8'hAB, "t6pre");
        s0 = n_strobe;
        i2c_start();
        send_byte(8'h7A, a0);
        send_byte(8'h30, a1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i2c_stop();
        check("t6_acks", {a0, a1}, 2'b00);
        check("t6_nostrobe", n_strobe - s0, 0);
        check("t6_idle", busy, 1'b0);
        read_local(8'h30, d); check("t6_reg30", d, 8'hAB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
